// File: rtl/i2s_pkg.sv
// Shared I2S capture types and constants.
// Imported by the receiver top and its input synchronizer.
package i2s_pkg;

  localparam int I2S_SAMPLE_BITS = 24;
  localparam int I2S_CNT_W       = 6;
  localparam int I2S_MIN_SYNC    = 2;

  typedef logic [I2S_SAMPLE_BITS-1:0] i2s_word_t;

  typedef struct packed {
    i2s_word_t left;
    i2s_word_t right;
  } i2s_frame_t;

  typedef enum logic {
    CH_LEFT  = 1'b0,
    CH_RIGHT = 1'b1
  } i2s_ch_t;

endpackage

// File: rtl/i2s_input_sync.sv
// Brings bck/lrck/sdata into the clk domain.
// Also produces a one-cycle pulse on each synchronized bck rise.
module i2s_input_sync
  import i2s_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic bck,
  input  logic lrck,
  input  logic sdata,
  output logic bck_rise,
  output logic lrck_sync,
  output logic sdata_sync
);

  localparam int STAGES =
    (SYNC_STAGES < I2S_MIN_SYNC) ? I2S_MIN_SYNC : SYNC_STAGES;

  logic [STAGES-1:0] bck_ff;
  logic [STAGES-1:0] lrck_ff;
  logic [STAGES-1:0] sdata_ff;
  logic              bck_prev;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bck_ff   <= '0;
      lrck_ff  <= '0;
      sdata_ff <= '0;
      bck_prev <= 1'b0;
    end else begin
      bck_ff   <= {bck_ff[STAGES-2:0], bck};
      lrck_ff  <= {lrck_ff[STAGES-2:0], lrck};
      sdata_ff <= {sdata_ff[STAGES-2:0], sdata};
      bck_prev <= bck_ff[STAGES-1];
    end
  end

  assign bck_rise   = bck_ff[STAGES-1] & ~bck_prev;
  assign lrck_sync  = lrck_ff[STAGES-1];
  assign sdata_sync = sdata_ff[STAGES-1];

endmodule

// File: rtl/i2s_receiver.sv
// I2S capture stage: deserializes MSB-first L/R words
// and hands {left, right} frames out over valid/ready.
module i2s_receiver
  import i2s_pkg::*;
#(
  parameter int SAMPLE_BITS = I2S_SAMPLE_BITS,
  parameter int DATA_DELAY  = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic                     bck,
  input  logic                     lrck,
  input  logic                     sdata,
  output logic                     samples_valid,
  input  logic                     samples_ready,
  output logic [2*SAMPLE_BITS-1:0] samples_data,
  output logic                     frame_error,
  output logic                     overflow,
  input  logic                     clear_status
);

  localparam logic [6:0] FIRST = 7'(DATA_DELAY);
  localparam logic [6:0] LAST  = 7'(DATA_DELAY + SAMPLE_BITS - 1);
  localparam logic [6:0] NBITS = 7'(SAMPLE_BITS);

  logic                   bck_rise;
  logic                   lrck_s;
  logic                   sdata_s;
  logic [I2S_CNT_W-1:0]   bit_cnt;
  logic                   lrck_prev;
  logic                   primed;
  logic                   synced;
  logic                   word_done;
  logic                   left_have;
  logic [SAMPLE_BITS-1:0] shift;
  logic [SAMPLE_BITS-1:0] left_word;

  logic                   boundary;
  logic [6:0]             cnt_eff;
  logic                   in_word;
  logic [SAMPLE_BITS-1:0] shift_nxt;
  logic                   word_last;
  logic                   frame_ready;
  logic                   err_set;
  logic                   ovf_set;
  i2s_ch_t                ch;

  i2s_input_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk       (clk),
    .reset     (reset),
    .bck       (bck),
    .lrck      (lrck),
    .sdata     (sdata),
    .bck_rise  (bck_rise),
    .lrck_sync (lrck_s),
    .sdata_sync(sdata_s)
  );

  // primed keeps the first rise after reset/enable from
  // being mistaken for an lrck boundary.
  always_comb begin
    ch          = i2s_ch_t'(lrck_s);
    boundary    = primed && (lrck_s != lrck_prev);
    cnt_eff     = boundary ? 7'd0 : ({1'b0, bit_cnt} + 7'd1);
    in_word     = (cnt_eff - FIRST) < NBITS;
    shift_nxt   = {shift[SAMPLE_BITS-2:0], sdata_s};
    word_last   = bck_rise && enable && synced &&
                  !boundary && (cnt_eff == LAST);
    err_set     = bck_rise && enable && boundary &&
                  synced && !word_done;
    frame_ready = word_last && (ch == CH_RIGHT) && left_have;
    ovf_set     = frame_ready && samples_valid && !samples_ready;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bit_cnt   <= '0;
      lrck_prev <= 1'b0;
      primed    <= 1'b0;
      synced    <= 1'b0;
      word_done <= 1'b0;
      left_have <= 1'b0;
      shift     <= '0;
      left_word <= '0;
    end else if (!enable) begin
      bit_cnt   <= '0;
      primed    <= 1'b0;
      synced    <= 1'b0;
      word_done <= 1'b0;
      left_have <= 1'b0;
      shift     <= '0;
    end else if (bck_rise) begin
      lrck_prev <= lrck_s;
      primed    <= 1'b1;
      if (boundary) begin
        bit_cnt   <= '0;
        synced    <= 1'b1;
        word_done <= 1'b0;
      end else if (bit_cnt != '1) begin
        bit_cnt <= bit_cnt + 1'b1;
      end
      if (in_word) shift <= shift_nxt;
      if (err_set) left_have <= 1'b0;
      if (word_last) begin
        word_done <= 1'b1;
        if (ch == CH_LEFT) begin
          left_word <= shift_nxt;
          left_have <= 1'b1;
        end else begin
          left_have <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      samples_valid <= 1'b0;
      samples_data  <= '0;
    end else if (frame_ready && (!samples_valid || samples_ready)) begin
      samples_valid <= 1'b1;
      samples_data  <= {left_word, shift_nxt};
    end else if (samples_valid && samples_ready) begin
      samples_valid <= 1'b0;
    end
  end

  // A same-cycle clear wins over a new error/overflow.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_error <= 1'b0;
      overflow    <= 1'b0;
    end else if (clear_status) begin
      frame_error <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      if (err_set) frame_error <= 1'b1;
      if (ovf_set) overflow    <= 1'b1;
    end
  end

endmodule
